// File: rtl/sram_burst_ctrl.sv
// Burst master port to single-ported synchronous SRAM: one word access per cycle, word address wraps at the top.
// Latency: write beat reaches SRAM next cycle; read beat i returns RD_LATENCY+2+i cycles after accept.
// Backpressure: waitrequest stays high from read accept until the cycle after its final rd_valid.
module sram_burst_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BURSTLEN_WIDTH = 2,
    parameter int SRAM_AW        = 24,
    parameter int RD_LATENCY     = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [BURSTLEN_WIDTH-1:0] burst_len,
    input  logic                      rd,
    input  logic                      wr,
    input  logic [DATA_WIDTH-1:0]     data_in,
    output logic                      waitrequest,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      rd_valid,
    output logic                      sram_ce,
    output logic                      sram_we,
    output logic [SRAM_AW-1:0]        sram_addr,
    output logic [DATA_WIDTH-1:0]     sram_wdata,
    input  logic [DATA_WIDTH-1:0]     sram_rdata
);
    localparam int BW = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t                    state_q;
    logic [BURSTLEN_WIDTH-1:0] cnt_q;
    logic [RD_LATENCY-1:0]     rvld_q;
    logic                      rd_valid_q;
    logic [DATA_WIDTH-1:0]     data_out_q;
    logic                      sram_ce_q;
    logic                      sram_we_q;
    logic [SRAM_AW-1:0]        sram_addr_q;
    logic [DATA_WIDTH-1:0]     sram_wdata_q;
    logic [SRAM_AW-1:0]        base_word;
    logic                      unused_addr;

    assign base_word   = addr[SRAM_AW+BW-1:BW];
    assign unused_addr = ^addr;

    assign waitrequest = !reset_n || (state_q == READ) || (state_q == DRAIN);
    assign data_out    = data_out_q;
    assign rd_valid    = rd_valid_q;
    assign sram_ce     = sram_ce_q;
    assign sram_we     = sram_we_q;
    assign sram_addr   = sram_addr_q;
    assign sram_wdata  = sram_wdata_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rvld_q       <= '0;
            rd_valid_q   <= 1'b0;
            data_out_q   <= '0;
            sram_ce_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            sram_ce_q  <= 1'b0;
            sram_we_q  <= 1'b0;
            // Track read issues so each returning word is tagged exactly when sram_rdata is valid.
            rvld_q     <= RD_LATENCY'({rvld_q, sram_ce_q & ~sram_we_q});
            rd_valid_q <= rvld_q[RD_LATENCY-1];
            if (rvld_q[RD_LATENCY-1]) begin
                data_out_q <= sram_rdata;
            end
            case (state_q)
                IDLE: begin
                    if (wr) begin
                        sram_ce_q    <= 1'b1;
                        sram_we_q    <= 1'b1;
                        sram_addr_q  <= base_word;
                        sram_wdata_q <= data_in;
                        cnt_q        <= burst_len;
                        if (burst_len != '0) begin
                            state_q <= WRITE;
                        end
                    end else if (rd) begin
                        sram_ce_q   <= 1'b1;
                        sram_addr_q <= base_word;
                        cnt_q       <= burst_len;
                        state_q     <= READ;
                    end
                end
                WRITE: begin
                    if (wr) begin
                        sram_ce_q    <= 1'b1;
                        sram_we_q    <= 1'b1;
                        sram_addr_q  <= sram_addr_q + SRAM_AW'(1);
                        sram_wdata_q <= data_in;
                        cnt_q        <= cnt_q - BURSTLEN_WIDTH'(1);
                        if (cnt_q == BURSTLEN_WIDTH'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                READ: begin
                    if (cnt_q == '0) begin
                        state_q <= DRAIN;
                    end else begin
                        sram_ce_q   <= 1'b1;
                        sram_addr_q <= sram_addr_q + SRAM_AW'(1);
                        cnt_q       <= cnt_q - BURSTLEN_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (rvld_q == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    wr_burst_no_rd: assert property (@(posedge clock) disable iff (!reset_n) !(state_q == WRITE && rd));

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Scoreboard bench for sram_burst_ctrl: reference memory model predicts SRAM accesses and read returns with cycle stamps.
module tb_sram_burst_ctrl;
    parameter int RDL = 2;

    logic        clock;
    logic        reset_n;
    logic [31:0] addr;
    logic [1:0]  burst_len;
    logic        rd;
    logic        wr;
    logic [31:0] data_in;
    logic        waitrequest;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        sram_ce;
    logic        sram_we;
    logic [7:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    sram_burst_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BURSTLEN_WIDTH(2), .SRAM_AW(8), .RD_LATENCY(RDL)
    ) dut (
        .clock(clock), .reset_n(reset_n), .addr(addr), .burst_len(burst_len), .rd(rd), .wr(wr),
        .data_in(data_in), .waitrequest(waitrequest), .data_out(data_out), .rd_valid(rd_valid),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] smem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] pipe [RDL];
    logic [31:0] wbuf [4];
    logic [63:0] acc_q [$];
    logic [63:0] ret_q [$];
    logic [31:0] last_dout = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // External SRAM: data for an address seen in cycle C appears on sram_rdata in cycle C+RDL.
    always @(posedge clock) begin
        pipe[0] <= smem[sram_addr];
        for (int k = 1; k < RDL; k++) pipe[k] <= pipe[k-1];
        if (sram_ce && sram_we) smem[sram_addr] <= sram_wdata;
    end
    assign sram_rdata = pipe[RDL-1];

    function automatic logic [63:0] acc_pack(input logic we, input logic [7:0] a, input logic [31:0] d, input int c);
        return {7'h0, we, a, (we ? d : 32'h0), c[15:0]};
    endfunction

    function automatic logic [63:0] ret_pack(input logic [31:0] d, input int c);
        return {16'h0, d, c[15:0]};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            last_dout = '0;
        end else begin
            if (sram_ce) begin
                if (acc_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sram_unexpected: got %h expected no access", acc_pack(sram_we, sram_addr, sram_wdata, cyc));
                end else begin
                    check("sram_access", acc_pack(sram_we, sram_addr, sram_wdata, cyc), acc_q.pop_front());
                end
            end
            if (rd_valid) begin
                if (ret_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL rd_unexpected: got %h expected no beat", ret_pack(data_out, cyc));
                end else begin
                    check("rd_beat", ret_pack(data_out, cyc), ret_q.pop_front());
                end
                last_dout = data_out;
            end else begin
                check("data_hold", {32'h0, data_out}, {32'h0, last_dout});
            end
        end
    end

    task automatic wait_accept(output int t);
        t = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (!waitrequest) begin
                t = cyc;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (t < 0) begin
            n_chk++;
            $display("FAIL accept_timeout: got waitrequest=1 expected 0 within 300 cycles");
        end
    endtask

    task automatic model_write(input logic [31:0] a, input int i, input int t);
        logic [7:0] w;
        w = 8'((a >> 2) + 32'(i));
        ref_mem[w] = wbuf[i];
        acc_q.push_back(acc_pack(1'b1, w, wbuf[i], t + 1));
    endtask

    task automatic read_tail(input logic [31:0] a, input int len, input int t);
        logic [7:0] w;
        int         rel;
        for (int i = 0; i <= len; i++) begin
            w = 8'((a >> 2) + 32'(i));
            acc_q.push_back(acc_pack(1'b0, w, 32'h0, t + 1 + i));
            ret_q.push_back(ret_pack(ref_mem[w], t + 2 + RDL + i));
        end
        @(posedge clock);
        #1;
        rd = 1'b0;
        rel = -1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clock);
            #1;
            if (!waitrequest) begin
                rel = cyc;
                break;
            end
        end
        check("rd_release", 64'(rel), 64'(t + 3 + RDL + len));
    endtask

    task automatic do_read(input logic [31:0] a, input int len);
        int t;
        rd = 1'b1;
        addr = a;
        burst_len = 2'(len);
        wait_accept(t);
        if (t >= 0) read_tail(a, len, t);
        rd = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input int stall_beat, input int stall_cyc);
        int t;
        for (int i = 0; i <= len; i++) begin
            if (i == stall_beat) begin
                repeat (stall_cyc) begin
                    wr = 1'b0;
                    @(negedge clock);
                    check("stall_waitreq", {63'h0, waitrequest}, 64'h0);
                    @(posedge clock);
                    #1;
                end
            end
            wr = 1'b1;
            addr = a;
            burst_len = 2'(len);
            data_in = wbuf[i];
            wait_accept(t);
            if (t >= 0) model_write(a, i, t);
            @(posedge clock);
            #1;
        end
        wr = 1'b0;
    endtask

    initial begin
        int t;
        int t2;
        reset_n = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
        addr = '0;
        burst_len = '0;
        data_in = '0;
        for (int i = 0; i < 256; i++) begin
            smem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
            ref_mem[i] = smem[i];
        end
        @(negedge clock);
        check("rst_waitreq", {63'h0, waitrequest}, 64'h1);
        check("rst_rd_valid", {63'h0, rd_valid}, 64'h0);
        check("rst_data_out", {32'h0, data_out}, 64'h0);
        check("rst_sram_ce", {63'h0, sram_ce}, 64'h0);
        check("rst_sram_we", {63'h0, sram_we}, 64'h0);
        check("rst_sram_addr", {56'h0, sram_addr}, 64'h0);
        check("rst_sram_wdata", {32'h0, sram_wdata}, 64'h0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Single write then single read of the same word
        wbuf[0] = 32'hDEAD_BEEF;
        do_write(32'h100, 0, 9, 0);
        do_read(32'h100, 0);

        // 4-beat write with a 2-cycle stall after the first beat, then read it back
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        do_write(32'h200, 3, 1, 2);
        do_read(32'h200, 3);

        // rd and wr together in IDLE: write wins, read follows the next cycle
        wbuf[0] = 32'hC0FF_EE01;
        wr = 1'b1;
        rd = 1'b1;
        addr = 32'h0A0;
        burst_len = 2'd0;
        data_in = wbuf[0];
        wait_accept(t);
        if (t >= 0) model_write(32'h0A0, 0, t);
        @(posedge clock);
        #1;
        wr = 1'b0;
        wait_accept(t2);
        check("rdwr_order", 64'(t2), 64'(t + 1));
        if (t2 >= 0) read_tail(32'h0A0, 0, t2);

        // Word address wrap at the top of the SRAM
        do_read(32'h3F8, 3);

        // Reset after the first returned beat of a 4-beat read
        rd = 1'b1;
        addr = 32'h200;
        burst_len = 2'd3;
        wait_accept(t);
        for (int i = 0; i < 4; i++) begin
            acc_q.push_back(acc_pack(1'b0, 8'(8'h80 + i), 32'h0, t + 1 + i));
            ret_q.push_back(ret_pack(ref_mem[8'h80 + i], t + 2 + RDL + i));
        end
        @(posedge clock);
        #1;
        rd = 1'b0;
        repeat (RDL + 2) @(posedge clock);
        #1;
        check("pre_reset_beats_left", 64'(ret_q.size()), 64'd3);
        reset_n = 1'b0;
        acc_q.delete();
        ret_q.delete();
        @(negedge clock);
        check("mid_rst_sram_ce", {63'h0, sram_ce}, 64'h0);
        check("mid_rst_rd_valid", {63'h0, rd_valid}, 64'h0);
        check("mid_rst_waitreq", {63'h0, waitrequest}, 64'h1);
        check("mid_rst_data_out", {32'h0, data_out}, 64'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (RDL + 4) @(posedge clock);
        #1;
        do_read(32'h204, 1);

        // Back-to-back 4-beat reads
        do_read(32'h040, 3);
        do_read(32'h080, 3);

        // Randomised mix of bursts
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int          len;
            a = $urandom;
            len = $urandom_range(0, 3);
            if ($urandom_range(0, 2) != 0) begin
                for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
                do_write(a, len, $urandom_range(0, 4), $urandom_range(0, 2));
            end else begin
                do_read(a, len);
            end
        end

        repeat (RDL + 6) @(posedge clock);
        #1;
        check("acc_queue_empty", 64'(acc_q.size()), 64'd0);
        check("ret_queue_empty", 64'(ret_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
